fifo_tx_serializer: RTL
=======================

Name: fifo_tx_serializer

Overview:
- Read-side consumer for the team's 4-bit show-ahead FIFO.
- Pops one word at a time, whenever the FIFO is non-empty and transmission is enabled.
- Shifts each word out as an asynchronous-serial frame: start bit, data LSB-first, optional even parity, stop bit.
- Sits between the FIFO read port and an off-chip or inter-block serial line.

Parameters:
- DATA_WIDTH, 4: word width; must match the FIFO data width.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range 1 or more.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstN  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- tx_enable  input  1  permits new frames to start; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO show-ahead head word; valid whenever fifo_empty=0.
- fifo_rd_en  output  1  FIFO pop strobe; pointer advances on the same clock edge.
- tx_serial  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is being sent.
- frame_done  output  1  one-cycle pulse in the final cycle of each stop bit.

Behaviour:
- Reset (rstN=0 at a rising edge):
  - state=IDLE, tx_serial=1, busy=0, frame_done=0, fifo_rd_en=0.
  - Baud counter, bit counter and shift register cleared.
  - Applies equally mid-frame. The interrupted word is dropped; it is not re-read.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - fifo_rd_en = tx_enable & ~fifo_empty, combinational, asserted only in IDLE.
  - When fifo_rd_en=1 in cycle T, fifo_rd_data is captured into the shift register at the edge ending T, and state goes to START.
  - fifo_rd_en never asserts while fifo_empty=1 or outside IDLE.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1.
  - Each state bit is held exactly CLKS_PER_BIT cycles.
  - The state advances on the edge where the counter equals CLKS_PER_BIT-1; the counter then reloads to 0.
- Latency: the start bit (tx_serial=0) appears in cycle T+1, one cycle after the pop cycle.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_serial = shift_reg[0]; the register shifts right once per bit.
  - The bit counter counts DATA_WIDTH bits.
  - Then goes to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_serial = XOR of the captured data word (even parity), then STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the last STOP cycle only.
  - Then IDLE.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames:
  - The IDLE cycle after STOP is mandatory, giving a 1-cycle line-high gap.
  - The next pop can occur in that IDLE cycle at the earliest.
- busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- tx_enable low mid-frame: the current frame completes normally; no further pop occurs until tx_enable=1.
- fifo_empty and fifo_rd_data are ignored outside IDLE.
- tx_serial is glitch-free (flop output); IDLE drives 1.

Test Plan:
- Reset: hold rstN=0 for 2 cycles with fifo_empty=0 and tx_enable=1 -> tx_serial=1, busy=0, fifo_rd_en=0, frame_done=0 throughout.
- Single word 4'hB, defaults (CLKS_PER_BIT=4, PARITY_EN=1), pop at cycle T:
  - tx_serial=0 for T+1..T+4.
  - Data bits 1,1,0,1 in cycles T+5..T+20.
  - Parity=1 in T+21..T+24.
  - Stop=1 in T+25..T+28.
  - frame_done=1 only at T+28; busy=1 for T+1..T+28.
- Back-to-back 4'h3 then 4'hC, defaults:
  - Exactly two fifo_rd_en pulses, at T and T+29.
  - Line high at T+29; second start bit at T+30..T+33.
  - Second parity bit=0.
  - No pop once fifo_empty=1.
- Gating:
  - fifo_empty=1 with tx_enable=1 for 100 cycles -> no fifo_rd_en, tx_serial=1.
  - tx_enable=0 with 4'h6 queued -> no pop.
  - tx_enable dropped during DATA -> frame finishes with frame_done, then no further pop.
- Reset mid-frame: assert rstN=0 during the second data bit -> next cycle tx_serial=1 and busy=0. After release with the FIFO non-empty, the next pop yields a fresh full frame of the next word.
- CLKS_PER_BIT=1, PARITY_EN=0, word 4'h5, pop at T -> tx_serial sequence 0,1,0,1,0,1 over T+1..T+6; frame_done at T+6.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// ============================================================================
// Module   : fifo_tx_serializer
// Brief    : Pops words from a show-ahead FIFO and sends each one as an async
//            serial frame: start, data LSB-first, optional even parity, stop.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_tx_serializer #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  r_parity;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  w_bit_end;

    assign w_bit_end  = (r_baud == C_BAUD_LAST);
    // Gated by rstN so the FIFO is never drained while the serializer is held in reset.
    assign fifo_rd_en = rstN && (r_state == IDLE) && tx_enable && !fifo_empty;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == STOP) && w_bit_end;
    assign tx_serial  = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                if (fifo_rd_en) begin
                    w_state_nxt = START;
                    w_shift_nxt = fifo_rd_data;
                end
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == C_BIT_LAST) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_bit_end) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Line value is computed for the state being entered so the flop output lines up with it.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = r_parity;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            if (r_state == IDLE) begin
                r_baud <= '0;
                r_bit  <= '0;
                if (fifo_rd_en) r_parity <= ^fifo_rd_data;
            end else if (w_bit_end) begin
                r_baud <= '0;
                if (r_state == DATA) r_bit <= (r_bit == C_BIT_LAST) ? '0 : r_bit + 1'b1;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
